online_resid_acc: RTL
=====================

Name: online_resid_acc

Overview:
- Residual accumulator and output-digit selector of the radix-2 online multiplier. Sits directly downstream of the two signed-digit vector multiplexer (SDVM) instances.
- Each step, sums the two selected redundant vectors into a shifted residual and selects one signed output digit.
- Drives the 2-bit STATE bus consumed by the SDVM instances. Sequences online-delay warm-up and digit emission.

Parameters:
Num_bits, 4, width of each SDVM vector (plus and minus halves).
DELTA, 3, online delay: accepted steps before the first output digit.
NUM_DIGITS, 4, output digits produced per operation.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
start  input  1  begin operation; honoured only in IDLE
write_enable  input  1  step strobe; vectors valid this cycle
vx_plus  input  Num_bits  SDVM A output, plus half
vx_minus  input  Num_bits  SDVM A output, minus half
vy_plus  input  Num_bits  SDVM B output, plus half
vy_minus  input  Num_bits  SDVM B output, minus half
STATE  output  2  00 IDLE, 01 WARMUP, 10 RUN, 11 DONE
z_digit  output  2  output digit: 10=+1, 01=-1, 00=0
z_valid  output  1  z_digit valid this cycle (one-cycle pulse)
busy  output  1  STATE != IDLE
done  output  1  one-cycle pulse in DONE
overflow  output  1  sticky residual overflow

Behaviour:
- Reset: all outputs 0. STATE=IDLE. Residual W=0. Step counter cnt=0.
- Residual W: signed two's complement, width WW=Num_bits+4.
- Each vector operand = zext(plus) - zext(minus), integer scale. A bitwise-complemented pair from the SDVM negates exactly.
- Step sum, computed at width WW+2: V = 2*W + (vx_plus - vx_minus) + (vy_plus - vy_minus).
- Digit selection, with H = 2^(Num_bits-1):
  - z=+1 if V >= H.
  - z=-1 if V < -H.
  - z=0 otherwise.
- W_next = V - z*2^Num_bits.
- The result is truncated to WW bits.
- overflow is set if the untruncated W_next lies outside the WW range.
- overflow clears only on start or rst.
- IDLE:
  - write_enable is ignored.
  - start=1 clears W, cnt and overflow, and moves to WARMUP next cycle.
- WARMUP:
  - Each write_enable updates W_next = V, with no selection and no digit output. cnt increments.
  - At the write_enable that makes cnt reach DELTA: cnt clears and STATE goes to RUN.
  - DELTA=0: skip WARMUP, go IDLE→RUN.
- RUN:
  - Each write_enable applies selection and updates W.
  - z_digit and z_valid are registered: they are valid the cycle after the write_enable. Latency is 1.
  - After NUM_DIGITS accepted steps, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
  - z_valid for the last digit coincides with the DONE cycle.
- write_enable=0 stalls:
  - W, cnt and STATE hold.
  - z_valid=0.
  - z_digit holds its last value.
- start while busy is ignored.
- rst mid-operation aborts immediately to the reset values.
- z_digit=11 is never produced.

Optional Feature:
ONLINE_RESID_SAT_EN
- Defined: W_next saturates to +(2^(WW-1)-1) or -2^(WW-1) instead of wrapping. overflow is still set when saturation occurs.
- Undefined: W_next wraps two's complement modulo 2^WW, and overflow flags the wrap.

Test Plan:
1. Defaults. start, 3 warm-up steps with all vectors 0, then a RUN step with vx_plus=9 and the rest 0 → V=9, z_digit=10, z_valid next cycle, W=-7.
2. Same setup, RUN step with vx_minus=9 → V=-9, z_digit=01, W=7. Next step with all vectors 0 → V=14, z_digit=10, W=-2.
3. Warm-up steps with vx_plus=vy_plus=15 → W=30, 90, then 210.
   - Wrap build: W=-46 and overflow=1.
   - ONLINE_RESID_SAT_EN build: W=127 and overflow=1.
4. Drop write_enable for 5 cycles mid-RUN → STATE, W and cnt frozen, z_valid=0. Resume → remaining digits emitted, total 4 z_valid pulses, done pulse once, STATE returns to 00.
5. Pulse start during RUN → ignored, digit count unchanged.
6. Assert rst during WARMUP → all outputs 0 asynchronously. A new start then runs a clean operation with overflow=0.

Source files
------------

// File: rtl/online_resid_acc.sv
// online_resid_acc: residual accumulator and output-digit selector of a
// radix-2 online multiplier, fed by two SDVM instances.
// Optional build macro: ONLINE_RESID_SAT_EN -- residual saturates instead of
// wrapping when the next residual leaves the WW-bit range.
module online_resid_acc #(
    parameter int unsigned Num_bits   = 4,
    parameter int unsigned DELTA      = 3,
    parameter int unsigned NUM_DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                write_enable,
    input  logic [Num_bits-1:0] vx_plus,
    input  logic [Num_bits-1:0] vx_minus,
    input  logic [Num_bits-1:0] vy_plus,
    input  logic [Num_bits-1:0] vy_minus,
    output logic [1:0]          STATE,
    output logic [1:0]          z_digit,
    output logic                z_valid,
    output logic                busy,
    output logic                done,
    output logic                overflow
);

    localparam int unsigned WW      = Num_bits + 4;
    localparam int unsigned VW      = WW + 2;
    localparam int unsigned CNT_MAX = (DELTA > NUM_DIGITS) ? DELTA : NUM_DIGITS;
    localparam int unsigned CW      = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

    // Selection thresholds, digit weight and residual range at the step-sum width
    localparam logic signed [VW-1:0] H_POS = VW'(2 ** (Num_bits - 1));
    localparam logic signed [VW-1:0] H_NEG = -H_POS;
    localparam logic signed [VW-1:0] UNIT  = VW'(2 ** Num_bits);
    localparam logic signed [VW-1:0] W_MAX = VW'((2 ** (WW - 1)) - 1);
    localparam logic signed [VW-1:0] W_MIN = -(VW'(2 ** (WW - 1)));

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_WARMUP = 2'b01,
        S_RUN    = 2'b10,
        S_DONE   = 2'b11
    } state_t;

    state_t                 state_q;
    logic signed [WW-1:0]   w_q;
    logic [CW-1:0]          cnt_q;
    logic [1:0]             z_digit_q;
    logic                   z_valid_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   ovf_q;

    logic signed [VW-1:0]   w_ext_c;
    logic signed [VW-1:0]   opx_c;
    logic signed [VW-1:0]   opy_c;
    logic signed [VW-1:0]   v_c;
    logic signed [VW-1:0]   wn_c;
    logic                   sel_pos_c;
    logic                   sel_neg_c;
    logic                   ovf_c;
    logic [WW-1:0]          w_d;
    logic [1:0]             z_d;

    // Step sum, digit selection (RUN only) and next residual with range handling
    always_comb begin
        w_ext_c   = {{(VW - WW){w_q[WW-1]}}, w_q};
        opx_c     = VW'(vx_plus) - VW'(vx_minus);
        opy_c     = VW'(vy_plus) - VW'(vy_minus);
        v_c       = (w_ext_c <<< 1) + opx_c + opy_c;
        sel_pos_c = (state_q == S_RUN) && (v_c >= H_POS);
        sel_neg_c = (state_q == S_RUN) && (v_c < H_NEG);
        wn_c      = v_c;
        z_d       = 2'b00;
        if (sel_pos_c) begin
            wn_c = v_c - UNIT;
            z_d  = 2'b10;
        end else if (sel_neg_c) begin
            wn_c = v_c + UNIT;
            z_d  = 2'b01;
        end
        ovf_c = (wn_c > W_MAX) || (wn_c < W_MIN);
`ifdef ONLINE_RESID_SAT_EN
        if (wn_c > W_MAX) begin
            w_d = WW'(W_MAX);
        end else if (wn_c < W_MIN) begin
            w_d = WW'(W_MIN);
        end else begin
            w_d = WW'(wn_c);
        end
`else
        w_d = WW'(wn_c);
`endif
    end

    // Sequencer: warm-up over DELTA steps, then NUM_DIGITS digit-emitting steps
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            w_q       <= '0;
            cnt_q     <= '0;
            z_digit_q <= 2'b00;
            z_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            z_valid_q <= 1'b0;
            done_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        w_q     <= '0;
                        cnt_q   <= '0;
                        ovf_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= (DELTA == 0) ? S_RUN : S_WARMUP;
                    end
                end
                S_WARMUP: begin
                    if (write_enable) begin
                        w_q   <= w_d;
                        ovf_q <= ovf_q | ovf_c;
                        if (cnt_q == CW'(DELTA - 1)) begin
                            cnt_q   <= '0;
                            state_q <= S_RUN;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
                S_RUN: begin
                    if (write_enable) begin
                        w_q       <= w_d;
                        ovf_q     <= ovf_q | ovf_c;
                        z_digit_q <= z_d;
                        z_valid_q <= 1'b1;
                        if (cnt_q == CW'(NUM_DIGITS - 1)) begin
                            cnt_q   <= '0;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign STATE    = state_q;
    assign z_digit  = z_digit_q;
    assign z_valid  = z_valid_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign overflow = ovf_q;

endmodule
